control_suma_multibyte: RTL and testbench
=========================================

Name: control_suma_multibyte

Overview:
- Sequencer for multi-precision addition built on an 8-bit add slice with carry chaining.
- Accepts two NBYTES-wide operands and a carry-in, then adds one byte per clock, LSB byte first, carrying between bytes through a carry register.
- Presents the full sum, carry-out and signed overflow with a start/busy/done handshake.
- Sits between a host/control FSM and the byte-wide adder datapath so that wide sums reuse one 8-bit slice.

Parameters:
- NBYTES, 4: operand width in bytes; legal range 2..16. Operand width W = 8*NBYTES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancels an operation in progress (ADD state only).
- A  in  W  operand A; sampled on the accepted start edge only.
- B  in  W  operand B; sampled on the accepted start edge only.
- Cin  in  1  initial carry into byte 0; sampled on the accepted start edge.
- busy  out  1  high while in the ADD state.
- done  out  1  one-cycle pulse; result is valid.
- S  out  W  sum register.
- Cout  out  1  carry out of the MSB byte.
- ovf  out  1  signed overflow: carry into bit W-1 XOR carry out of bit W-1.

Behaviour:
- Reset: state IDLE; busy=0, done=0, S=0, Cout=0, ovf=0; internal byte index=0; carry register=0; operand registers=0.
- States: IDLE, ADD and DONE. All outputs are registered.
- IDLE with start=1 on an edge:
  - Latch A, B and Cin (Cin into the carry register).
  - Clear S, Cout and ovf; set index=0.
  - Go to ADD. busy=1 from the next cycle.
- IDLE with start=0: hold all outputs.
- ADD, each edge:
  - Compute byte[idx] = A_byte + B_byte + carry, a 9-bit result.
  - Write the low 8 bits into S[8*idx+7:8*idx]; write bit 8 into the carry register; increment idx.
  - When idx = NBYTES-1 (last byte):
    - Also set Cout to the final carry.
    - Set ovf = carry into bit 7 of that byte XOR its carry out.
    - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
- Latency: start accepted at edge 0; bytes are processed at edges 1..NBYTES. done is high in the cycle after edge NBYTES and low again after edge NBYTES+1.
- Throughput: one operation per NBYTES+2 cycles. A start held high through DONE is accepted on the first IDLE edge.
- start is ignored in ADD and DONE; latched operands are not disturbed by changes on A, B or Cin.
- abort in ADD:
  - Return to IDLE on that edge; done never pulses.
  - Clear S, Cout and ovf to 0.
  - abort in IDLE or DONE has no effect. If abort and start are both high in IDLE, start wins.
- S, Cout and ovf hold their values after DONE until the next accepted start, abort or rst.
- rst has priority over everything, including mid-operation; it returns to the reset state in the same edge.
- Arithmetic is unsigned modulo 2^W; Cout is bit W of the full sum. No partial bytes exist.

Test Plan (NBYTES=4):
- Carry ripple: A=0xFFFFFFFF, B=0x00000001, Cin=0, start pulse → busy high for 4 cycles; done pulse 5th cycle after start edge; S=0x00000000, Cout=1, ovf=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, Cin=0 → S=0x80000000, Cout=0, ovf=1, done pulse once.
- Carry-in: A=0x12345678, B=0x11111111, Cin=1 → S=0x2345678A, Cout=0, ovf=0.
- Start while busy: start during ADD with A=0xAAAAAAAA → ignored; original result is delivered. Start held high through DONE → a second operation begins on the IDLE edge, with done pulses separated by 6 cycles.
- Abort: abort asserted on 2nd ADD cycle → busy drops next cycle, no done pulse, S=0, Cout=0; a following start completes normally.
- Reset mid-op: rst on 3rd ADD cycle → next cycle all outputs 0 and state IDLE; a subsequent A=0x00000005, B=0x00000003 yields S=0x00000008.

Source files
------------

// File: rtl/control_suma_multibyte.sv
// ============================================================================
// control_suma_multibyte : sequences an NBYTES-wide add through one 8-bit
// slice, LSB byte first, with start/busy/done handshake.   Revision 1.0
// ============================================================================
`default_nettype none

module control_suma_multibyte #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  Cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   S,
  output logic                  Cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [7:0]      byte_a, byte_b;
  logic [8:0]      sum9;
  logic            carry_into_msb;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    byte_a = a_q[8*idx_q +: 8];
    byte_b = b_q[8*idx_q +: 8];
    sum9   = {1'b0, byte_a} + {1'b0, byte_b} + {8'd0, carry_q};
    // Carry entering bit 7 recovered from the sum bit and its two addends.
    carry_into_msb = byte_a[7] ^ byte_b[7] ^ sum9[7];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (abort) begin
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          s_d[8*idx_q +: 8] = sum9[7:0];
          carry_d           = sum9[8];
          idx_d             = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_d  = sum9[8];
            ovf_d   = carry_into_msb ^ sum9[8];
            idx_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_control_suma_multibyte.sv
// Testbench for control_suma_multibyte (NBYTES=4): table vectors, random
// operations against an arithmetic model, and multi-cycle corner sequences.
`default_nettype none

module tb_control_suma_multibyte;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout, ovf;
  logic [W-1:0] S;

  int checks = 0;
  int errors = 0;

  control_suma_multibyte #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic; overflow from the two's-complement sign rule.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // Issues a start on one edge; returns at the sample point one cycle later.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic with_abort);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1; abort = with_abort;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  // Follows the operation cycle by cycle, scrambling the inputs while busy.
  task automatic finish_op(input string name, input logic [W-1:0] es,
                           input logic ec, input logic eo);
    logic timing_ok;
    timing_ok = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) begin
        A = $urandom; B = $urandom; Cin = 1'($urandom);
      end
      if (busy !== (k <= 4) || done !== (k == 5)) timing_ok = 1'b0;
    end
    chk({name, ".timing"}, 64'(timing_ok), 64'd1);
    chk({name, ".S"}, 64'(S), 64'(es));
    chk({name, ".Cout"}, 64'(Cout), 64'(ec));
    chk({name, ".ovf"}, 64'(ovf), 64'(eo));
    @(negedge clk);
    chk({name, ".done_low"}, {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ms, ra, rb;
    logic mc, mo, rc;
    int done_cnt, first_done, second_done, cyc;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.outs", {29'd0, busy, done, Cout, ovf}, 64'd0);
    chk("reset.S", 64'(S), 64'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      finish_op($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);
    end

    // abort in IDLE must leave the held result untouched
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort.S", 64'(S), 64'h00000001);

    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if (n == 0) rb = ~ra;
      model(ra, rb, rc, ms, mc, mo);
      start_op(ra, rb, rc, 1'b0);
      finish_op($sformatf("rnd%0d", n), ms, mc, mo);
    end

    // start during ADD ignored; start held through DONE begins the next op
    start_op(32'h00000001, 32'h00000002, 1'b0, 1'b0);
    A = 32'hAAAAAAAA; B = 32'h11111111; Cin = 1'b0; start = 1'b1;
    done_cnt = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = k;
          chk("held.first_S", 64'(S), 64'h00000003);
        end else if (done_cnt == 2) begin
          second_done = k;
          start = 1'b0;
          chk("held.second_S", 64'(S), 64'hBBBBBBBB);
          chk("held.second_flags", {62'd0, Cout, ovf}, 64'd0);
        end
      end
    end
    start = 1'b0;
    chk("held.done_count", 64'(done_cnt), 64'd2);
    chk("held.first_at", 64'(first_done), 64'd5);
    chk("held.spacing", 64'(second_done - first_done), 64'd6);
    repeat (4) @(negedge clk);

    // abort on the second ADD cycle
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.outs", {61'd0, busy, done, Cout, ovf}, 64'd0);
    chk("abort.S", 64'(S), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("abort.no_done", 64'(done_cnt), 64'd0);
    // start and abort together in IDLE: start wins
    start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b1);
    finish_op("after_abort", 32'h00000100, 1'b0, 1'b0);

    // synchronous reset on the third ADD cycle
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.outs", {61'd0, busy, done, Cout, ovf}, 64'd0);
    chk("rst_mid.S", 64'(S), 64'd0);
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) cyc++;
    end
    chk("rst_mid.idle", 64'(cyc), 64'd0);
    start_op(32'h00000005, 32'h00000003, 1'b0, 1'b0);
    finish_op("after_rst", 32'h00000008, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
